// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body block.
package snake_pkg;

  localparam int GRID     = 8;
  localparam int MAX_LEN  = 16;
  localparam int INIT_LEN = 3;

  // Starting snake lies on row 3, head at column 2 pointing right.
  localparam logic [2:0]  INIT_ROW  = 3'd3;
  // Row 3, columns 0..2 -> bits 24..26.
  localparam logic [63:0] INIT_INFO = 64'h0000_0000_0700_0000;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
  } pos_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_UPDATE,
    ST_REQ,
    ST_DEAD
  } state_t;

  // Opposite directions differ only in the upper encoding bit.
  function automatic logic is_opposite(input dir_t a, input dir_t b);
    return (2'(a) ^ 2'(b)) == 2'b10;
  endfunction

  // Bit position of a cell in the occupancy map.
  function automatic logic [5:0] cell_index(input pos_t p);
    return 6'(int'(p.row) * GRID + int'(p.col));
  endfunction

  // Segment i of the snake straight after reset; unused slots are zero.
  function automatic pos_t init_seg(input int i);
    pos_t p;
    p = '0;
    if (i < INIT_LEN) begin
      p.row = INIT_ROW;
      p.col = 3'(INIT_LEN - 1 - i);
    end
    return p;
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Next head cell one step from the current head, wrapping on the 8x8 grid.
module snake_next_head
  import snake_pkg::*;
(
  input  pos_t cur,
  input  dir_t dir,
  output pos_t nxt
);

  // 3-bit arithmetic gives the modulo-8 wrap for free.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    nxt = cur;
    unique case (dir)
      DIR_UP:    nxt.row = cur.row - 3'd1;
      DIR_DOWN:  nxt.row = cur.row + 3'd1;
      DIR_LEFT:  nxt.col = cur.col - 3'd1;
      DIR_RIGHT: nxt.col = cur.col + 3'd1;
    endcase
  end

endmodule

// File: rtl/snake_body.sv
// Snake body tracker: segment shift register, eat/collision detection,
// occupancy map and apple request handshake.
module snake_body
  import snake_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        tick,
  input  logic [1:0]  dir,
  input  logic [2:0]  apple_c,
  input  logic [2:0]  apple_r,
  output logic [63:0] info,
  output logic        apple_req,
  output logic [2:0]  head_c,
  output logic [2:0]  head_r,
  output logic [4:0]  len,
  output logic        dead
);

  pos_t        seg [MAX_LEN];
  logic [4:0]  len_q;
  dir_t        cur_dir;
  state_t      state, state_nxt;
  logic        eat_q;
  logic        dead_q;
  logic [63:0] info_q;

  dir_t        req_dir;
  dir_t        eff_dir;
  pos_t        next_head;
  pos_t        apple;
  logic        accept;
  logic        eat;
  logic        grow;
  logic        hit;
  logic [63:0] info_build;

  assign req_dir = dir_t'(dir);
  // A reversal would run the head straight into the neck, so it is dropped.
  assign eff_dir = is_opposite(req_dir, cur_dir) ? cur_dir : req_dir;

  snake_next_head u_next_head (
    .cur (seg[0]),
    .dir (eff_dir),
    .nxt (next_head)
  );

  assign apple  = '{row: apple_r, col: apple_c};
  assign accept = tick && (state == ST_RUN);
  assign eat    = (next_head == apple);
  assign grow   = eat && (len_q < 5'(MAX_LEN));

  // Collision against the body; the tail only counts when it stays put (growth).
  always_comb begin
    hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((5'(i) < len_q) && (next_head == seg[i])) begin
        if (grow || (5'(i) != len_q - 5'd1)) hit = 1'b1;
      end
    end
  end

  // Occupancy map assembled from the live segments.
  always_comb begin
    info_build = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (5'(i) < len_q) info_build[cell_index(seg[i])] = 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge CLK) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (RST) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // Next-state logic: move, rebuild the map, then optionally ask for an apple.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:    if (accept) state_nxt = hit ? ST_DEAD : ST_UPDATE;
      ST_UPDATE: state_nxt = eat_q ? ST_REQ : ST_RUN;
      ST_REQ:    state_nxt = ST_RUN;
      ST_DEAD:   state_nxt = ST_DEAD;
    endcase
  end

  // Segment array, length, heading and the sticky collision flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the segment array is small and its contents are architectural
      // (head, map), so every slot is reset rather than left undefined.
      for (int i = 0; i < MAX_LEN; i++) seg[i] <= init_seg(i);
      len_q   <= 5'(INIT_LEN);
      cur_dir <= DIR_RIGHT;
      eat_q   <= 1'b0;
      dead_q  <= 1'b0;
    end else if (accept) begin
      if (hit) begin
        dead_q <= 1'b1;
      end else begin
        // Shifting every slot keeps the old tail one past the end, so growth
        // just extends len over it.
        seg[0] <= next_head;
        for (int i = MAX_LEN - 1; i > 0; i--) seg[i] <= seg[i-1];
        if (grow) len_q <= len_q + 5'd1;
        cur_dir <= eff_dir;
        eat_q   <= eat;
      end
    end
  end

  // The published map only moves on the cycle after a successful step.
  always_ff @(posedge CLK) begin
    if (RST)                     info_q <= INIT_INFO;
    else if (state == ST_UPDATE) info_q <= info_build;
  end

  assign info      = info_q;
  assign apple_req = (state == ST_REQ);
  assign head_c    = seg[0].col;
  assign head_r    = seg[0].row;
  assign len       = len_q;
  assign dead      = dead_q;

endmodule

// File: tb/tb_snake_body.sv
// Randomised self-checking bench for snake_body against a queue-based model.
module tb_snake_body;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        tick = 1'b0;
  logic [1:0]  dir = 2'd1;
  logic [2:0]  apple_c = 3'd0;
  logic [2:0]  apple_r = 3'd0;
  logic [63:0] info;
  logic        apple_req;
  logic [2:0]  head_c;
  logic [2:0]  head_r;
  logic [4:0]  len;
  logic        dead;

  snake_body dut (
    .CLK       (CLK),
    .RST       (RST),
    .tick      (tick),
    .dir       (dir),
    .apple_c   (apple_c),
    .apple_r   (apple_r),
    .info      (info),
    .apple_req (apple_req),
    .head_c    (head_c),
    .head_r    (head_r),
    .len       (len),
    .dead      (dead)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the snake as a list of cells, head first.
  int          mr[$];
  int          mc[$];
  int          mdir;
  bit          mdead;
  logic [63:0] minfo;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_map();
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < mr.size(); i++) m[mr[i]*8 + mc[i]] = 1'b1;
    return m;
  endfunction

  function automatic int eff_of(input int d);
    return (((d + 2) % 4) == mdir) ? mdir : d;
  endfunction

  task automatic model_next(input int d, output int nr, output int nc);
    nr = mr[0];
    nc = mc[0];
    case (eff_of(d))
      0:       nr = (nr + 7) % 8;
      1:       nc = (nc + 1) % 8;
      2:       nr = (nr + 1) % 8;
      default: nc = (nc + 7) % 8;
    endcase
  endtask

  task automatic model_reset();
    mr    = '{3, 3, 3};
    mc    = '{2, 1, 0};
    mdir  = 1;
    mdead = 1'b0;
    minfo = model_map();
  endtask

  task automatic model_step(input int d, input int ar, input int ac, output bit eat);
    int nr, nc, lim;
    bit grow, coll;
    eat = 1'b0;
    if (mdead) return;
    model_next(d, nr, nc);
    eat  = (nr == ar) && (nc == ac);
    grow = eat && (mr.size() < 16);
    lim  = grow ? mr.size() : mr.size() - 1;
    coll = 1'b0;
    for (int i = 1; i < lim; i++) if (mr[i] == nr && mc[i] == nc) coll = 1'b1;
    if (coll) begin
      mdead = 1'b1;
      eat   = 1'b0;
      return;
    end
    mdir = eff_of(d);
    mr.push_front(nr);
    mc.push_front(nc);
    if (!grow) begin
      void'(mr.pop_back());
      void'(mc.pop_back());
    end
  endtask

  task automatic check_state(input string tag, input bit exp_req);
    check({tag, "_info"},   info,            minfo);
    check({tag, "_head_r"}, 64'(head_r),     64'(mr[0]));
    check({tag, "_head_c"}, 64'(head_c),     64'(mc[0]));
    check({tag, "_len"},    64'(len),        64'(mr.size()));
    check({tag, "_dead"},   64'(dead),       64'(mdead));
    check({tag, "_req"},    64'(apple_req),  64'(exp_req));
  endtask

  // One tick; outputs are checked after edge k, k+1 and k+2.
  task automatic do_move(input int d, input int ar, input int ac, input bit dbl, input int idle);
    bit eat;
    @(negedge CLK);
    tick = 1'b1; dir = 2'(d); apple_r = 3'(ar); apple_c = 3'(ac);
    @(negedge CLK);
    tick = dbl;
    model_step(d, ar, ac, eat);
    check_state("move_k", 1'b0);
    @(negedge CLK);
    tick = 1'b0;
    if (!mdead) minfo = model_map();
    check_state("move_k1", eat);
    @(negedge CLK);
    check("move_k2_req", 64'(apple_req), 64'd0);
    repeat (idle) @(negedge CLK);
  endtask

  task automatic do_reset(input bit with_tick);
    @(negedge CLK);
    RST = 1'b1; tick = with_tick; dir = 2'($urandom_range(0, 3));
    apple_r = 3'($urandom_range(0, 7)); apple_c = 3'($urandom_range(0, 7));
    @(negedge CLK);
    RST = 1'b0; tick = 1'b0;
    model_reset();
    check_state("reset", 1'b0);
  endtask

  initial begin
    logic [63:0] saved_info;
    int          dead_moves;
    int          d, ar, ac, nr, nc;

    // Reset values.
    do_reset(1'b0);
    check("rst_info_const", info, 64'h0000_0000_0700_0000);
    check("rst_len_const",  64'(len), 64'd3);
    check("rst_head_const", 64'({head_r, head_c}), 64'({3'd3, 3'd2}));

    // Reversal from reset is ignored; head keeps moving right.
    do_move(3, 0, 0, 1'b0, 0);
    check("rev_head", 64'({head_r, head_c}), 64'({3'd3, 3'd3}));

    // Wrap across the right edge.
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) do_move(1, 0, 0, 1'b0, 1);
    check("wrap_head", 64'({head_r, head_c}), 64'({3'd3, 3'd0}));
    check("wrap_info", info, 64'h0000_0000_C100_0000);

    // Eat grows the snake and pulses apple_req two cycles after the tick.
    do_reset(1'b0);
    do_move(1, 3, 3, 1'b1, 0);
    check("eat_len",  64'(len), 64'd4);
    check("eat_info", info, 64'h0000_0000_0F00_0000);

    // Grow to five, then curl back into the body.
    do_reset(1'b0);
    do_move(1, 3, 3, 1'b0, 0);
    do_move(1, 3, 4, 1'b0, 0);
    do_move(2, 0, 0, 1'b0, 0);
    do_move(3, 0, 0, 1'b0, 0);
    do_move(0, 0, 0, 1'b0, 0);
    check("coll_dead", 64'(dead), 64'd1);
    saved_info = info;
    do_move(1, 0, 0, 1'b0, 0);
    do_move(2, 0, 0, 1'b1, 0);
    check("coll_info_frozen", info, saved_info);
    check("coll_len_frozen",  64'(len), 64'd5);

    // Reset during UPDATE after an eat, with a tick arriving at the same edge.
    do_reset(1'b0);
    @(negedge CLK);
    tick = 1'b1; dir = 2'd1; apple_r = 3'd3; apple_c = 3'd3;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0; tick = 1'b0;
    model_reset();
    check_state("abort_upd", 1'b0);
    @(negedge CLK);
    check_state("abort_upd_next", 1'b0);

    // Reset while apple_req is high.
    @(negedge CLK);
    tick = 1'b1; dir = 2'd1; apple_r = 3'd3; apple_c = 3'd3;
    @(negedge CLK);
    tick = 1'b0;
    @(negedge CLK);
    check("abort_req_pulse", 64'(apple_req), 64'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    check_state("abort_req", 1'b0);

    // Random play with frequent apples placed in the head's path.
    do_reset(1'b0);
    dead_moves = 0;
    for (int n = 0; n < 400; n++) begin
      d = $urandom_range(0, 3);
      if ($urandom_range(0, 2) != 0) begin
        model_next(d, nr, nc);
        ar = nr; ac = nc;
      end else begin
        ar = $urandom_range(0, 7);
        ac = $urandom_range(0, 7);
      end
      do_move(d, ar, ac, ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
      if (mdead) dead_moves++;
      if (dead_moves >= 2 || $urandom_range(0, 79) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
        dead_moves = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
